// File: rtl/ila_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ila_pkg
// Description : Shared types and helpers for the ila_capture logic-analyzer
//               core: trigger-mode encoding, capture FSM states and the
//               address-width helper used to size pointers and ports.
// Revision    : 1.0 - initial release
// ============================================================================
package ila_pkg;

   // Trigger condition selected by the host on trig_mode.
   typedef enum logic [1:0] {
      TRIG_RISE = 2'b00,
      TRIG_FALL = 2'b01,
      TRIG_HIGH = 2'b10,
      TRIG_NOW  = 2'b11
   } trig_mode_e;

   // Capture state machine.
   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_PRE  = 3'd1,
      ST_WAIT = 3'd2,
      ST_POST = 3'd3,
      ST_DONE = 3'd4
   } state_e;

   // Index width for a buffer of the given depth (at least 1 bit).
   function automatic int addr_width(input int depth);
      return (depth <= 2) ? 1 : $clog2(depth);
   endfunction

endpackage
`default_nettype wire

// File: rtl/ila_capture_if.sv
`default_nettype none
// ============================================================================
// Module      : ila_capture_if
// Description : Probe, control and readback bundle of the ila_capture core.
//               master : host / emulator side (drives probes, arm, mode and
//                        read index; observes status and read data)
//               slave  : the capture core
// Signals     : probe0    data probe
//               probe1    event probe (bit 0 feeds the trigger)
//               arm       one-cycle capture start / restart pulse
//               trig_mode trigger condition select
//               busy / triggered / done  capture status
//               rd_addr   window read index, 0 = oldest sample
//               rd_data   {probe1, probe0} of the indexed sample, registered
// Revision    : 1.0 - initial release
// ============================================================================
interface ila_capture_if #(
   parameter int P0_WIDTH = 64,
   parameter int P1_WIDTH = 1,
   parameter int DEPTH    = 1024
);
   localparam int AW = ila_pkg::addr_width(DEPTH);

   logic [P0_WIDTH-1:0]          probe0;
   logic [P1_WIDTH-1:0]          probe1;
   logic                         arm;
   logic [1:0]                   trig_mode;
   logic                         busy;
   logic                         triggered;
   logic                         done;
   logic [AW-1:0]                rd_addr;
   logic [P1_WIDTH+P0_WIDTH-1:0] rd_data;

   modport master (
      output probe0, probe1, arm, trig_mode, rd_addr,
      input  busy, triggered, done, rd_data
   );

   modport slave (
      input  probe0, probe1, arm, trig_mode, rd_addr,
      output busy, triggered, done, rd_data
   );

endinterface
`default_nettype wire

// File: rtl/ila_sample_ram.sv
`default_nettype none
// ============================================================================
// Module      : ila_sample_ram
// Description : Simple dual-port sample memory, one write port and one
//               synchronous read port. The array itself is not reset so it
//               maps onto block RAM; only the read output register is reset.
// Ports       : clk      sample clock
//               rst_n    asynchronous active-low reset (read register only)
//               wr_en    write strobe
//               wr_addr  write index
//               wr_data  write word
//               rd_addr  read index
//               rd_data  registered read word, valid one clk after rd_addr
// Revision    : 1.0 - initial release
// ============================================================================
module ila_sample_ram
   import ila_pkg::*;
#(
   parameter int WIDTH = 65,
   parameter int DEPTH = 1024
) (
   input  logic                                clk,
   input  logic                                rst_n,
   input  logic                                wr_en,
   input  logic [addr_width(DEPTH)-1:0]        wr_addr,
   input  logic [WIDTH-1:0]                    wr_data,
   input  logic [addr_width(DEPTH)-1:0]        rd_addr,
   output logic [WIDTH-1:0]                    rd_data
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [WIDTH-1:0] rd_data_q;

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_data_q <= '0;
      end else begin
         rd_data_q <= mem[rd_addr];
      end
   end

   assign rd_data = rd_data_q;

endmodule
`default_nettype wire

// File: rtl/ila_capture.sv
`default_nettype none
// ============================================================================
// Module      : ila_capture
// Description : Integrated logic-analyzer capture core. Samples
//               {probe1, probe0} into a circular buffer, fires on a
//               selectable probe1[0] condition and freezes a window of
//               PRE_TRIG samples before and DEPTH-PRE_TRIG samples from the
//               trigger sample on. The window is read back oldest-first.
// Ports       : clk    sample clock (emu_clk)
//               rst_n  asynchronous active-low reset
//               bus    ila_capture_if.slave (probes, arm, trig_mode, status,
//                      rd_addr / rd_data readback)
// Revision    : 1.0 - initial release
// ============================================================================
module ila_capture
   import ila_pkg::*;
#(
   parameter int P0_WIDTH = 64,
   parameter int P1_WIDTH = 1,
   parameter int DEPTH    = 1024,
   parameter int PRE_TRIG = DEPTH / 2
) (
   input  logic         clk,
   input  logic         rst_n,
   ila_capture_if.slave bus
);

   localparam int AW = addr_width(DEPTH);
   localparam int DW = P1_WIDTH + P0_WIDTH;

   localparam logic [AW-1:0] C_PRE_OFS   = AW'(PRE_TRIG);
   localparam logic [AW-1:0] C_PRE_LAST  = AW'((PRE_TRIG > 0) ? PRE_TRIG - 1 : 0);
   localparam logic [AW-1:0] C_POST_LAST = AW'(DEPTH - PRE_TRIG - 1);
   localparam logic [AW-1:0] C_ONE       = AW'(1);
   // With PRE_TRIG = DEPTH-1 the trigger sample alone completes the window.
   localparam bit            C_POST_ONE  = ((DEPTH - PRE_TRIG) == 1);
   // With no pre-trigger history the capture starts directly in WAIT.
   localparam state_e        C_ARM_STATE = (PRE_TRIG == 0) ? ST_WAIT : ST_PRE;

   state_e        state_q,     state_d;
   logic [AW-1:0] wptr_q,      wptr_d;
   logic [AW-1:0] cnt_q,       cnt_d;
   logic [AW-1:0] trig_ptr_q,  trig_ptr_d;
   logic          prev_p1_q,   prev_p1_d;
   logic          busy_q,      busy_d;
   logic          triggered_q, triggered_d;
   logic          done_q,      done_d;

   logic          wr_en;
   logic [DW-1:0] wr_data;
   logic [AW-1:0] rd_phys;
   logic [DW-1:0] rd_data;
   logic          p1_now;
   logic          rise;
   logic          fall;
   logic          trig_hit;
   trig_mode_e    mode;

   assign p1_now  = bus.probe1[0];
   assign rise    = p1_now & ~prev_p1_q;
   assign fall    = ~p1_now & prev_p1_q;
   assign mode    = trig_mode_e'(bus.trig_mode);
   assign wr_data = {bus.probe1, bus.probe0};

   // Window index 0 is PRE_TRIG samples before the trigger sample; the
   // subtraction wraps naturally because DEPTH is a power of two.
   assign rd_phys = trig_ptr_q - C_PRE_OFS + bus.rd_addr;

   always_comb begin
      trig_hit = 1'b0;
      case (mode)
         TRIG_RISE: trig_hit = rise;
         TRIG_FALL: trig_hit = fall;
         TRIG_HIGH: trig_hit = p1_now;
         TRIG_NOW:  trig_hit = 1'b1;
         default:   trig_hit = 1'b0;
      endcase
   end

   always_comb begin
      state_d     = state_q;
      wptr_d      = wptr_q;
      cnt_d       = cnt_q;
      trig_ptr_d  = trig_ptr_q;
      busy_d      = busy_q;
      triggered_d = triggered_q;
      done_d      = done_q;
      prev_p1_d   = p1_now;
      wr_en       = 1'b0;

      if (bus.arm) begin
         // Restart from any state; the arm cycle itself stores nothing.
         state_d     = C_ARM_STATE;
         wptr_d      = '0;
         cnt_d       = '0;
         busy_d      = 1'b1;
         triggered_d = 1'b0;
         done_d      = 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
            end
            ST_PRE: begin
               wr_en  = 1'b1;
               wptr_d = wptr_q + C_ONE;
               cnt_d  = cnt_q + C_ONE;
               if (cnt_q == C_PRE_LAST) begin
                  state_d = ST_WAIT;
                  cnt_d   = '0;
               end
            end
            ST_WAIT: begin
               wr_en  = 1'b1;
               wptr_d = wptr_q + C_ONE;
               if (trig_hit) begin
                  trig_ptr_d  = wptr_q;
                  triggered_d = 1'b1;
                  if (C_POST_ONE) begin
                     state_d = ST_DONE;
                     busy_d  = 1'b0;
                     done_d  = 1'b1;
                  end else begin
                     state_d = ST_POST;
                     cnt_d   = C_ONE;   // trigger sample already stored
                  end
               end
            end
            ST_POST: begin
               wr_en  = 1'b1;
               wptr_d = wptr_q + C_ONE;
               cnt_d  = cnt_q + C_ONE;
               if (cnt_q == C_POST_LAST) begin
                  state_d = ST_DONE;
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
               end
            end
            ST_DONE: begin
            end
            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         wptr_q      <= '0;
         cnt_q       <= '0;
         trig_ptr_q  <= '0;
         prev_p1_q   <= 1'b0;
         busy_q      <= 1'b0;
         triggered_q <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         wptr_q      <= wptr_d;
         cnt_q       <= cnt_d;
         trig_ptr_q  <= trig_ptr_d;
         prev_p1_q   <= prev_p1_d;
         busy_q      <= busy_d;
         triggered_q <= triggered_d;
         done_q      <= done_d;
      end
   end

   ila_sample_ram #(
      .WIDTH (DW),
      .DEPTH (DEPTH)
   ) u_ram (
      .clk     (clk),
      .rst_n   (rst_n),
      .wr_en   (wr_en),
      .wr_addr (wptr_q),
      .wr_data (wr_data),
      .rd_addr (rd_phys),
      .rd_data (rd_data)
   );

   assign bus.busy      = busy_q;
   assign bus.triggered = triggered_q;
   assign bus.done      = done_q;
   assign bus.rd_data   = rd_data;

endmodule
`default_nettype wire

// File: tb/tb_ila_capture.sv
`default_nettype none
// ============================================================================
// Module      : tb_ila_capture
// Description : Directed self-checking bench for ila_capture with DEPTH = 16,
//               PRE_TRIG = 8. probe0 carries the sample index since arm;
//               probe1 follows a per-test high-window pattern.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ila_capture;

   localparam int P0W   = 64;
   localparam int P1W   = 1;
   localparam int DEPTH = 16;
   localparam int PRE   = 8;
   localparam int DW    = P0W + P1W;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;

   ila_capture_if #(.P0_WIDTH(P0W), .P1_WIDTH(P1W), .DEPTH(DEPTH)) bus ();

   ila_capture #(
      .P0_WIDTH (P0W),
      .P1_WIDTH (P1W),
      .DEPTH    (DEPTH),
      .PRE_TRIG (PRE)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   // probe1 is high for sample index k in [a1,b1) or [a2,b2).
   int a1 = 1000, b1 = 1000, a2 = 1000, b2 = 1000;

   function automatic logic p1_at(input int k);
      return ((k >= a1) && (k < b1)) || ((k >= a2) && (k < b2));
   endfunction

   task automatic check_eq(input string tag, input logic [DW-1:0] got,
                           input logic [DW-1:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic set_pattern(input int x1, input int y1, input int x2, input int y2);
      a1 = x1; b1 = y1; a2 = x2; b2 = y2;
   endtask

   task automatic drive_sample(input int k);
      bus.probe0 = 64'(k);
      bus.probe1 = p1_at(k);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Arms, streams samples, and (unless stopped early) checks trigger
   // timing, completion and the whole 16-entry window.
   task automatic capture(input string tag, input logic [1:0] mode,
                          input int exp_trig, input int stop_after);
      int k;
      int trig_k;
      int s;
      logic [DW-1:0] exp_word;
      bus.trig_mode = mode;
      drive_sample(-1);
      bus.arm = 1'b1;
      step();
      bus.arm = 1'b0;
      check_eq($sformatf("%s arm_flags", tag),
               {bus.busy, bus.triggered, bus.done}, 3'b100);
      trig_k = -1;
      for (k = 0; k < 64; k++) begin
         if ((stop_after >= 0) && (k == stop_after)) return;
         drive_sample(k);
         step();
         if (bus.triggered && (trig_k < 0)) trig_k = k;
         if (bus.done) break;
      end
      check_eq($sformatf("%s trig_sample", tag), trig_k, exp_trig);
      check_eq($sformatf("%s done_sample", tag), k, exp_trig + DEPTH - PRE - 1);
      check_eq($sformatf("%s done_flags", tag),
               {bus.busy, bus.triggered, bus.done}, 3'b011);
      for (int a = 0; a < DEPTH; a++) begin
         bus.rd_addr = 4'(a);
         step();
         s = exp_trig - PRE + a;
         exp_word = {p1_at(s), 64'(s)};
         check_eq($sformatf("%s rd[%0d]", tag, a), bus.rd_data, exp_word);
      end
   endtask

   initial begin
      bus.probe0    = '0;
      bus.probe1    = '0;
      bus.arm       = 1'b0;
      bus.trig_mode = 2'b00;
      bus.rd_addr   = '0;
      #2 rst_n = 1'b0;
      #10;
      check_eq("reset flags", {bus.busy, bus.triggered, bus.done}, 3'b000);
      check_eq("reset rd_data", bus.rd_data, '0);
      #1 rst_n = 1'b1;
      step();

      // Mode 00, single rising edge at sample 20 -> window 12..27.
      set_pattern(20, 1000, 1000, 1000);
      capture("rise20", 2'b00, 20, -1);
      bus.rd_addr = 4'd8;
      step();
      check_eq("rise20 trig_word", bus.rd_data, {1'b1, 64'd20});

      // Reset mid-PRE: status and rd_data drop without a clock edge.
      bus.rd_addr = 4'd15;
      set_pattern(1000, 1000, 1000, 1000);
      capture("rst_pre", 2'b11, 0, 4);
      #2 rst_n = 1'b0;
      #1;
      check_eq("rst_pre flags", {bus.busy, bus.triggered, bus.done}, 3'b000);
      check_eq("rst_pre rd_data", bus.rd_data, '0);
      #1 rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         drive_sample(i);
         step();
      end
      check_eq("rst_pre idle", {bus.busy, bus.triggered, bus.done}, 3'b000);

      // Reset mid-POST clears triggered too.
      capture("rst_post", 2'b11, 8, 12);
      check_eq("rst_post pre_flags", {bus.busy, bus.triggered, bus.done}, 3'b110);
      #2 rst_n = 1'b0;
      #1;
      check_eq("rst_post flags", {bus.busy, bus.triggered, bus.done}, 3'b000);
      #1 rst_n = 1'b1;
      step();

      // Edge inside PRE ignored; second edge at 30 -> window 22..37.
      set_pattern(3, 6, 30, 1000);
      capture("rise_pre", 2'b00, 30, -1);

      // Falling edge at 10 (probe1 high since before arm) -> window 2..17.
      set_pattern(-100, 10, 1000, 1000);
      capture("fall10", 2'b01, 10, -1);

      // Level high held from arm -> trigger on first WAIT sample.
      set_pattern(-100, 1000, 1000, 1000);
      capture("high", 2'b10, 8, -1);

      // Immediate -> trigger at sample 8, done after sample 15.
      set_pattern(1000, 1000, 1000, 1000);
      capture("now", 2'b11, 8, -1);

      // Read latency: rd_data follows rd_addr exactly one clk later.
      bus.rd_addr = 4'd3;
      step();
      check_eq("lat first", bus.rd_data, {1'b0, 64'd3});
      bus.rd_addr = 4'd9;
      #1;
      check_eq("lat hold", bus.rd_data, {1'b0, 64'd3});
      step();
      check_eq("lat update", bus.rd_data, {1'b0, 64'd9});

      // Re-arm during POST: triggered clears, new capture completes.
      capture("rearm0", 2'b11, 8, 11);
      check_eq("rearm0 post_flags", {bus.busy, bus.triggered, bus.done}, 3'b110);
      set_pattern(20, 1000, 1000, 1000);
      capture("rearm1", 2'b00, 20, -1);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

   // Absolute time guard so the bench can never hang.
   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, required completion");
      $fatal(1, "timeout");
   end

endmodule
`default_nettype wire
